// File: rtl/pulse_burst_sequencer.sv
// Burst sequencer: on a start edge, latches on-time/period/count and issues one
// single-cycle trigger per effective period to a downstream square-wave generator.
module pulse_burst_sequencer #(
   parameter int WIDTH       = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [WIDTH-1:0]       on_cycles_i,
   input  logic [WIDTH-1:0]       period_i,
   input  logic [COUNT_WIDTH-1:0] n_pulses_i,
   output logic                   trig_o,
   output logic [WIDTH-1:0]       on_cycles_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [COUNT_WIDTH-1:0] pulses_sent_o
);

   typedef enum logic {
      IDLE,
      RUN
   } state_e;

   state_e                 state_q, state_d;
   logic                   start_q;
   logic                   start_e;
   logic [WIDTH:0]         on_plus2;
   logic [WIDTH:0]         period_ext;
   logic [WIDTH:0]         p_eff;
   logic [WIDTH:0]         period_q, period_d;
   logic [WIDTH:0]         cnt, cnt_d;
   logic [COUNT_WIDTH-1:0] n_q, n_d;
   logic [COUNT_WIDTH-1:0] pulses_d;
   logic [WIDTH-1:0]       on_d;
   logic                   trig_d, done_d, busy_d;

   assign start_e = start_i & ~start_q;

   // The period is widened by one bit so on_cycles + 2 never wraps, even at all-ones.
   assign on_plus2   = {1'b0, on_cycles_i} + (WIDTH+1)'(2);
   assign period_ext = {1'b0, period_i};
   assign p_eff      = (period_ext > on_plus2) ? period_ext : on_plus2;

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      cnt_d    = cnt;
      n_d      = n_q;
      pulses_d = pulses_sent_o;
      on_d     = on_cycles_o;
      trig_d   = 1'b0;
      done_d   = 1'b0;
      busy_d   = busy_o;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start_e && !abort_i) begin
               if (n_pulses_i != '0) begin
                  n_d      = n_pulses_i;
                  period_d = p_eff;
                  on_d     = on_cycles_i;
                  trig_d   = 1'b1;
                  pulses_d = COUNT_WIDTH'(1);
                  cnt_d    = p_eff - (WIDTH+1)'(1);
                  busy_d   = 1'b1;
                  state_d  = RUN;
               end else begin
                  pulses_d = '0;
                  done_d   = 1'b1;
               end
            end
         end
         RUN: begin
            // Abort takes priority over counting, triggering and completion.
            if (abort_i) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (cnt != '0) begin
               cnt_d = cnt - (WIDTH+1)'(1);
            end else if (pulses_sent_o < n_q) begin
               trig_d   = 1'b1;
               pulses_d = pulses_sent_o + COUNT_WIDTH'(1);
               cnt_d    = period_q - (WIDTH+1)'(1);
            end else begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         start_q       <= 1'b0;
         period_q      <= '0;
         cnt           <= '0;
         n_q           <= '0;
         pulses_sent_o <= '0;
         on_cycles_o   <= '0;
         trig_o        <= 1'b0;
         done_o        <= 1'b0;
         busy_o        <= 1'b0;
      end else begin
         state_q       <= state_d;
         start_q       <= start_i;
         period_q      <= period_d;
         cnt           <= cnt_d;
         n_q           <= n_d;
         pulses_sent_o <= pulses_d;
         on_cycles_o   <= on_d;
         trig_o        <= trig_d;
         done_o        <= done_d;
         busy_o        <= busy_d;
      end
   end

endmodule

// File: tb/tb_pulse_burst_sequencer.sv
// Directed bench for pulse_burst_sequencer; expected trigger/done events are
// queued when a burst is started and matched as the DUT emits them.
module tb_pulse_burst_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i;
   logic        abort_i;
   logic [31:0] on_cycles_i;
   logic [31:0] period_i;
   logic [15:0] n_pulses_i;
   logic        trig_o;
   logic [31:0] on_cycles_o;
   logic        busy_o;
   logic        done_o;
   logic [15:0] pulses_sent_o;

   pulse_burst_sequencer #(.WIDTH(32), .COUNT_WIDTH(16)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .on_cycles_i  (on_cycles_i),
      .period_i     (period_i),
      .n_pulses_i   (n_pulses_i),
      .trig_o       (trig_o),
      .on_cycles_o  (on_cycles_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .pulses_sent_o(pulses_sent_o)
   );

   always #5 clk_i = ~clk_i;

   // Edge counter: at a falling edge it equals the number of rising edges so far.
   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      bit          isDone;
      int          cyc;
      int          pulses;
      int          busy;
      logic [31:0] onc;
   } exp_t;

   exp_t expQ[$];
   int   passes  = 0;
   int   checks  = 0;
   int   busyRun = 0;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
   endtask

   task automatic stepCycle();
      exp_t e;
      @(negedge clk_i);
      if (busy_o) busyRun++;
      if (trig_o || done_o) begin
         if (expQ.size() == 0) begin
            checkOutput("spurious_event", 64'({trig_o, done_o}), 64'(0));
         end else begin
            e = expQ.pop_front();
            checkOutput(e.isDone ? "done_kind" : "trig_kind", 64'({trig_o, done_o}),
                        64'(e.isDone ? 2'b01 : 2'b10));
            checkOutput("event_cycle", 64'(cyc), 64'(e.cyc));
            checkOutput("pulses_sent", 64'(pulses_sent_o), 64'(e.pulses));
            checkOutput("on_cycles_o", 64'(on_cycles_o), 64'(e.onc));
            if (e.isDone) checkOutput("busy_cycles", 64'(busyRun), 64'(e.busy));
            else          checkOutput("busy_at_trig", 64'(busy_o), 64'(1));
         end
      end
      if (!busy_o) busyRun = 0;
   endtask

   task automatic runCycles(input int n);
      repeat (n) stepCycle();
   endtask

   // Drives a start edge (called just after a falling edge) and queues expected events.
   task automatic applyStimulus(input logic [31:0] onc, input logic [31:0] per, input logic [15:0] n,
                                input int nTrig, input bit expDone, input logic [31:0] expOnc);
      logic [32:0] p;
      int          s;
      exp_t        e;
      on_cycles_i = onc;
      period_i    = per;
      n_pulses_i  = n;
      start_i     = 1'b1;
      p = ({1'b0, per} > ({1'b0, onc} + 33'd2)) ? {1'b0, per} : ({1'b0, onc} + 33'd2);
      s = cyc + 1;
      for (int k = 0; k < nTrig; k++) begin
         e.isDone = 1'b0;
         e.cyc    = s + k * int'(p[31:0]);
         e.pulses = k + 1;
         e.busy   = 0;
         e.onc    = expOnc;
         expQ.push_back(e);
      end
      if (expDone) begin
         e.isDone = 1'b1;
         e.cyc    = s + int'(n) * int'(p[31:0]);
         e.pulses = int'(n);
         e.busy   = int'(n) * int'(p[31:0]);
         e.onc    = expOnc;
         expQ.push_back(e);
      end
      $display("[TB] start: on=%0d period=%0d n=%0d P=%0d edge0=%0d", onc, per, n, p, s);
   endtask

   initial begin
      rst_ni      = 1'b0;
      start_i     = 1'b0;
      abort_i     = 1'b0;
      on_cycles_i = '0;
      period_i    = '0;
      n_pulses_i  = '0;
      #3;
      checkOutput("reset_trig", 64'(trig_o), 64'(0));
      checkOutput("reset_on_cycles", 64'(on_cycles_o), 64'(0));
      checkOutput("reset_busy", 64'(busy_o), 64'(0));
      checkOutput("reset_done", 64'(done_o), 64'(0));
      checkOutput("reset_pulses", 64'(pulses_sent_o), 64'(0));
      runCycles(2);
      rst_ni = 1'b1;
      runCycles(2);

      // Basic burst: P = 10, four triggers, done after edge 40.
      applyStimulus(32'd3, 32'd10, 16'd4, 4, 1'b1, 32'd3);
      runCycles(1);
      start_i = 1'b0;
      runCycles(45);
      checkOutput("t1_queue_empty", 64'(expQ.size()), 64'(0));
      checkOutput("t1_pulses_final", 64'(pulses_sent_o), 64'(4));
      checkOutput("t1_busy_final", 64'(busy_o), 64'(0));

      // Period shorter than on_cycles+2 is clamped to 10.
      applyStimulus(32'd8, 32'd5, 16'd3, 3, 1'b1, 32'd8);
      runCycles(1);
      start_i = 1'b0;
      runCycles(35);
      checkOutput("t2_queue_empty", 64'(expQ.size()), 64'(0));

      // Zero-length burst: done only, on_cycles_o keeps the previous latch.
      applyStimulus(32'd5, 32'd7, 16'd0, 0, 1'b1, 32'd8);
      runCycles(1);
      start_i = 1'b0;
      runCycles(5);
      checkOutput("t3_queue_empty", 64'(expQ.size()), 64'(0));
      checkOutput("t3_pulses", 64'(pulses_sent_o), 64'(0));

      // Abort sampled at edge 16 of a P=10, N=5 burst.
      applyStimulus(32'd3, 32'd10, 16'd5, 2, 1'b0, 32'd3);
      runCycles(1);
      start_i = 1'b0;
      runCycles(15);
      abort_i = 1'b1;
      runCycles(1);
      abort_i = 1'b0;
      runCycles(1);
      checkOutput("t4_busy_after_abort", 64'(busy_o), 64'(0));
      runCycles(30);
      checkOutput("t4_queue_empty", 64'(expQ.size()), 64'(0));
      checkOutput("t4_pulses", 64'(pulses_sent_o), 64'(2));

      // Abort and start edge together in IDLE: edge consumed, nothing starts.
      on_cycles_i = 32'd2;
      period_i    = 32'd6;
      n_pulses_i  = 16'd2;
      start_i     = 1'b1;
      abort_i     = 1'b1;
      runCycles(1);
      abort_i = 1'b0;
      runCycles(8);
      checkOutput("t5_busy", 64'(busy_o), 64'(0));
      checkOutput("t5_queue_empty", 64'(expQ.size()), 64'(0));
      start_i = 1'b0;
      runCycles(1);

      // Held start, extra edge and config changes mid-burst are all ignored.
      applyStimulus(32'd4, 32'd12, 16'd2, 2, 1'b1, 32'd4);
      runCycles(5);
      on_cycles_i = 32'd1;
      period_i    = 32'd3;
      n_pulses_i  = 16'd9;
      start_i     = 1'b0;
      runCycles(1);
      start_i = 1'b1;
      runCycles(30);
      checkOutput("t6_queue_empty", 64'(expQ.size()), 64'(0));
      checkOutput("t6_on_cycles_held", 64'(on_cycles_o), 64'(4));
      start_i = 1'b0;
      runCycles(1);
      applyStimulus(32'd1, 32'd3, 16'd2, 2, 1'b1, 32'd1);
      runCycles(1);
      start_i = 1'b0;
      runCycles(10);
      checkOutput("t6b_queue_empty", 64'(expQ.size()), 64'(0));

      // Asynchronous reset mid-burst clears outputs at once; burst does not resume.
      applyStimulus(32'd3, 32'd10, 16'd3, 1, 1'b0, 32'd3);
      runCycles(1);
      start_i = 1'b0;
      runCycles(6);
      #2 rst_ni = 1'b0;
      #1;
      checkOutput("rst_mid_trig", 64'(trig_o), 64'(0));
      checkOutput("rst_mid_on_cycles", 64'(on_cycles_o), 64'(0));
      checkOutput("rst_mid_busy", 64'(busy_o), 64'(0));
      checkOutput("rst_mid_done", 64'(done_o), 64'(0));
      checkOutput("rst_mid_pulses", 64'(pulses_sent_o), 64'(0));
      runCycles(2);
      rst_ni = 1'b1;
      runCycles(30);
      checkOutput("t7_queue_empty", 64'(expQ.size()), 64'(0));
      checkOutput("t7_busy", 64'(busy_o), 64'(0));
      applyStimulus(32'd2, 32'd4, 16'd2, 2, 1'b1, 32'd2);
      runCycles(1);
      start_i = 1'b0;
      runCycles(12);
      checkOutput("t7b_queue_empty", 64'(expQ.size()), 64'(0));

      // All-ones on_cycles: P = 2^32 + 1 must fit the counter without wrapping.
      applyStimulus(32'hFFFF_FFFF, 32'd5, 16'd1, 1, 1'b0, 32'hFFFF_FFFF);
      runCycles(1);
      checkOutput("t8_cnt_start", 64'(dut.cnt), 64'h1_0000_0000);
      start_i = 1'b0;
      runCycles(3);
      checkOutput("t8_cnt_after3", 64'(dut.cnt), 64'h0_FFFF_FFFD);
      abort_i = 1'b1;
      runCycles(1);
      abort_i = 1'b0;
      runCycles(3);
      checkOutput("t8_queue_empty", 64'(expQ.size()), 64'(0));
      checkOutput("t8_busy", 64'(busy_o), 64'(0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
